// File: rtl/xreg_pkg.sv
// Shared types and helpers for the xregs software-access path.
package xreg_pkg;

    localparam int unsigned XREG_LANE_W     = 4;
    localparam int unsigned XREG_NLANE      = 3;
    localparam int unsigned XREG_MAX_NLANE  = 8;
    localparam int unsigned XREG_MAX_LANE_W = 16;
    localparam int unsigned XREG_MAX_DW     = XREG_MAX_NLANE * XREG_MAX_LANE_W;
    localparam int unsigned XREG_IDX_W      = $clog2(XREG_MAX_DW);
    localparam int unsigned XREG_BE_IDX_W   = $clog2(XREG_MAX_NLANE);

    typedef enum logic [2:0] {
        StIdle,
        StWstb,
        StRstb,
        StRwait,
        StRsp
    } xreg_ms_state_t;

    // Expand per-lane enables into a bit mask: bit (l*lane_w + b) follows be[l].
    // Callers truncate the result to their own data width.
    function automatic logic [XREG_MAX_DW-1:0] xreg_lane_mask(
        input logic [XREG_MAX_NLANE-1:0] be,
        input int unsigned               lane_w
    );
        logic [XREG_MAX_DW-1:0] m;
        logic [XREG_IDX_W-1:0]  idx;
        m = '0;
        for (int unsigned l = 0; l < XREG_MAX_NLANE; l++) begin
            for (int unsigned b = 0; b < XREG_MAX_LANE_W; b++) begin
                if (b < lane_w && (l * lane_w + b) < XREG_MAX_DW) begin
                    idx    = XREG_IDX_W'(l * lane_w + b);
                    m[idx] = be[XREG_BE_IDX_W'(l)];
                end
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/xreg_sw_master_if.sv
// Host request/response channel plus the field-side lane signals of xreg_sw_master.
interface xreg_sw_master_if import xreg_pkg::*; #(
    parameter int unsigned LANE_W = XREG_LANE_W,
    parameter int unsigned NLANE  = XREG_NLANE
);
    localparam int unsigned DW = LANE_W * NLANE;

    logic             req_valid;
    logic             req_ready;
    logic             req_write;
    logic [NLANE-1:0] req_be;
    logic [DW-1:0]    req_wdata;
    logic [NLANE-1:0] sw_rd;
    logic [NLANE-1:0] sw_wr;
    logic [DW-1:0]    sw_wr_data;
    logic [DW-1:0]    fld_rdata;
    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_write;
    logic             rsp_err;
    logic [DW-1:0]    rsp_rdata;

    // master: the access initiator itself
    modport master (
        input  req_valid, req_write, req_be, req_wdata, fld_rdata, rsp_ready,
        output req_ready, sw_rd, sw_wr, sw_wr_data, rsp_valid, rsp_write, rsp_err, rsp_rdata
    );

    // slave: host adapter plus field instances
    modport slave (
        output req_valid, req_write, req_be, req_wdata, fld_rdata, rsp_ready,
        input  req_ready, sw_rd, sw_wr, sw_wr_data, rsp_valid, rsp_write, rsp_err, rsp_rdata
    );

endinterface

// File: rtl/xreg_sw_master.sv
// Software-side access initiator: one host request -> one-cycle lane strobe -> one response.
module xreg_sw_master import xreg_pkg::*; #(
    parameter int unsigned LANE_W = XREG_LANE_W,
    parameter int unsigned NLANE  = XREG_NLANE,
    parameter int unsigned RD_LAT = 1
) (
    input logic               clk,
    input logic               sync_rst,
    xreg_sw_master_if.master  bus
);

    localparam int unsigned DW = LANE_W * NLANE;

    xreg_ms_state_t   state_q, state_d;
    logic             write_q, write_d;
    logic [NLANE-1:0] be_q, be_d;
    logic [DW-1:0]    wdata_q, wdata_d;
    logic [DW-1:0]    rdata_q, rdata_d;
    logic [1:0]       cnt_q, cnt_d;
    logic [DW-1:0]    lane_mask;
    logic             sample;

    // Lane mask from the captured enables; disabled lanes read back as zero.
    always_comb begin
        lane_mask = DW'(xreg_lane_mask(XREG_MAX_NLANE'(be_q), LANE_W));
    end

    // Next-state: request capture, strobe sequencing and read-latency countdown.
    always_comb begin
        state_d = state_q;
        write_d = write_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        sample  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.req_valid) begin
                    write_d = bus.req_write;
                    be_d    = bus.req_be;
                    wdata_d = bus.req_wdata;
                    rdata_d = '0;
                    if (bus.req_be == '0) begin
                        state_d = StRsp;
                    end else if (bus.req_write) begin
                        state_d = StWstb;
                    end else begin
                        state_d = StRstb;
                    end
                end
            end
            StWstb: state_d = StRsp;
            StRstb: begin
                if (RD_LAT == 0) begin
                    sample  = 1'b1;
                    state_d = StRsp;
                end else begin
                    cnt_d   = 2'(RD_LAT - 1);
                    state_d = StRwait;
                end
            end
            StRwait: begin
                if (cnt_q == '0) begin
                    sample  = 1'b1;
                    state_d = StRsp;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            StRsp: begin
                if (bus.rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        if (sample) begin
            rdata_d = bus.fld_rdata & lane_mask;
        end
    end

    // State register; reset drops any in-flight request.
    always_ff @(posedge clk) begin
        if (sync_rst) begin
            state_q <= StIdle;
            write_q <= 1'b0;
            be_q    <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            write_q <= write_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs decoded from state; everything is zero outside its own state.
    always_comb begin
        bus.req_ready  = (state_q == StIdle);
        bus.sw_wr      = (state_q == StWstb) ? be_q : '0;
        bus.sw_wr_data = (state_q == StWstb) ? wdata_q : '0;
        bus.sw_rd      = (state_q == StRstb) ? be_q : '0;
        bus.rsp_valid  = (state_q == StRsp);
        bus.rsp_write  = (state_q == StRsp) && write_q;
        bus.rsp_err    = (state_q == StRsp) && (be_q == '0);
        bus.rsp_rdata  = (state_q == StRsp) ? rdata_q : '0;
    end

endmodule

// File: tb/tb_xreg_sw_master.sv
// Bench: three instances (RD_LAT 0, 1, 3) share host stimulus; a cycle-indexed
// transaction model predicts every output of every instance each cycle.
module tb_xreg_sw_master;
    import xreg_pkg::*;

    localparam int LW   = XREG_LANE_W;
    localparam int NL   = XREG_NLANE;
    localparam int DW   = LW * NL;
    localparam int NDUT = 3;
    localparam int OW   = 2 * DW + 2 * NL + 4;
    localparam int NVEC = 8;

    typedef struct {
        bit            wr;
        logic [NL-1:0] be;
        logic [DW-1:0] wd;
        logic [DW-1:0] fld;
        logic [DW-1:0] exp_rd;
        bit            exp_err;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic          sync_rst  = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_write = 1'b0;
    logic [NL-1:0] req_be    = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] fld_drv [NDUT];

    logic [OW-1:0] obs     [NDUT];
    logic          o_ready [NDUT];
    logic          o_rv    [NDUT];
    logic          o_rw    [NDUT];
    logic          o_err   [NDUT];
    logic [NL-1:0] o_swr   [NDUT];
    logic [NL-1:0] o_sww   [NDUT];
    logic [DW-1:0] o_swd   [NDUT];
    logic [DW-1:0] o_rdata [NDUT];

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int unsigned LAT = (g == 0) ? 0 : (g == 1) ? 1 : 3;
        xreg_sw_master_if #(.LANE_W(LW), .NLANE(NL)) bus ();
        assign bus.req_valid = req_valid;
        assign bus.req_write = req_write;
        assign bus.req_be    = req_be;
        assign bus.req_wdata = req_wdata;
        assign bus.rsp_ready = rsp_ready;
        assign bus.fld_rdata = fld_drv[g];
        assign o_ready[g] = bus.req_ready;
        assign o_rv[g]    = bus.rsp_valid;
        assign o_rw[g]    = bus.rsp_write;
        assign o_err[g]   = bus.rsp_err;
        assign o_swr[g]   = bus.sw_rd;
        assign o_sww[g]   = bus.sw_wr;
        assign o_swd[g]   = bus.sw_wr_data;
        assign o_rdata[g] = bus.rsp_rdata;
        assign obs[g] = {bus.req_ready, bus.sw_rd, bus.sw_wr, bus.sw_wr_data,
                         bus.rsp_valid, bus.rsp_write, bus.rsp_err, bus.rsp_rdata};
        xreg_sw_master #(.LANE_W(LW), .NLANE(NL), .RD_LAT(LAT)) u_dut (
            .clk      (clk),
            .sync_rst (sync_rst),
            .bus      (bus)
        );
    end

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    // Reference model: one pending transaction per instance, indexed by cycle number.
    bit            pend [NDUT];
    int            acc  [NDUT];
    bit            m_wr [NDUT];
    logic [NL-1:0] m_be [NDUT];
    logic [DW-1:0] m_wd [NDUT];
    logic [DW-1:0] m_rd [NDUT];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    function automatic int lat_of(input int d);
        return (d == 0) ? 0 : (d == 1) ? 1 : 3;
    endfunction

    function automatic int lat_total(input bit wr, input logic [NL-1:0] be, input int d);
        if (be == '0) return 1;
        if (wr) return 2;
        return lat_of(d) + 2;
    endfunction

    function automatic logic [DW-1:0] keep_lanes(input logic [DW-1:0] fld, input logic [NL-1:0] be);
        logic [DW-1:0] r;
        logic [DW-1:0] one_lane;
        r = '0;
        one_lane = {{(DW - LW){1'b0}}, {LW{1'b1}}};
        for (int i = 0; i < NL; i++) begin
            if (((be >> i) & NL'(1)) != '0) r = r | (fld & (one_lane << (i * LW)));
        end
        return r;
    endfunction

    function automatic logic [OW-1:0] expect_obs(input int d, input int c);
        logic          rdy, rv, rw, re;
        logic [NL-1:0] swr, sww;
        logic [DW-1:0] swd, rr;
        rdy = !pend[d];
        rv = 1'b0; rw = 1'b0; re = 1'b0;
        swr = '0; sww = '0; swd = '0; rr = '0;
        if (pend[d]) begin
            if (c == acc[d] + 1 && m_be[d] != '0) begin
                if (m_wr[d]) begin
                    sww = m_be[d];
                    swd = m_wd[d];
                end else begin
                    swr = m_be[d];
                end
            end
            if (c >= acc[d] + lat_total(m_wr[d], m_be[d], d)) begin
                rv = 1'b1;
                rw = m_wr[d];
                re = (m_be[d] == '0);
                rr = m_rd[d];
            end
        end
        return {rdy, swr, sww, swd, rv, rw, re, rr};
    endfunction

    task automatic model_step(input int d, input int c);
        if (sync_rst) begin
            pend[d] = 1'b0;
        end else if (!pend[d]) begin
            if (req_valid) begin
                pend[d] = 1'b1;
                acc[d]  = c;
                m_wr[d] = req_write;
                m_be[d] = req_be;
                m_wd[d] = req_wdata;
                m_rd[d] = '0;
            end
        end else begin
            if (!m_wr[d] && m_be[d] != '0 && c == acc[d] + 1 + lat_of(d))
                m_rd[d] = keep_lanes(fld_drv[d], m_be[d]);
            if (c >= acc[d] + lat_total(m_wr[d], m_be[d], d) && rsp_ready)
                pend[d] = 1'b0;
        end
    endtask

    // Per-cycle scoreboard, sampled mid-cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int d = 0; d < NDUT; d++) begin
                check($sformatf("scb lat%0d cyc%0d", lat_of(d), cyc),
                      64'(obs[d]), 64'(expect_obs(d, cyc)));
                model_step(d, cyc);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        bit busy;
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        busy = 1'b1;
        for (int k = 0; k < 30 && busy; k++) begin
            step();
            busy = pend[0] | pend[1] | pend[2];
        end
        check("idle_all drain", 64'(busy), 64'(0));
    endtask

    vec_t vecs [NVEC];
    bit   seen [NDUT];

    initial begin
        for (int d = 0; d < NDUT; d++) begin
            fld_drv[d] = '0;
            pend[d] = 1'b0;
            acc[d] = 0;
            m_wr[d] = 1'b0;
            m_be[d] = '0;
            m_wd[d] = '0;
            m_rd[d] = '0;
        end
        vecs[0] = '{wr: 1'b1, be: 3'b101, wd: 12'h3A5, fld: 12'h000, exp_rd: 12'h000, exp_err: 1'b0};
        vecs[1] = '{wr: 1'b0, be: 3'b011, wd: 12'h000, fld: 12'h333, exp_rd: 12'h033, exp_err: 1'b0};
        vecs[2] = '{wr: 1'b1, be: 3'b000, wd: 12'hFFF, fld: 12'h000, exp_rd: 12'h000, exp_err: 1'b1};
        vecs[3] = '{wr: 1'b0, be: 3'b000, wd: 12'h000, fld: 12'hFFF, exp_rd: 12'h000, exp_err: 1'b1};
        vecs[4] = '{wr: 1'b0, be: 3'b111, wd: 12'h000, fld: 12'hABC, exp_rd: 12'hABC, exp_err: 1'b0};
        vecs[5] = '{wr: 1'b0, be: 3'b100, wd: 12'h000, fld: 12'h9C4, exp_rd: 12'h900, exp_err: 1'b0};
        vecs[6] = '{wr: 1'b0, be: 3'b001, wd: 12'h000, fld: 12'h9C4, exp_rd: 12'h004, exp_err: 1'b0};
        vecs[7] = '{wr: 1'b1, be: 3'b010, wd: 12'h5A5, fld: 12'h000, exp_rd: 12'h000, exp_err: 1'b0};

        // Reset held for three cycles.
        sync_rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < NDUT; d++)
            check($sformatf("reset lat%0d", lat_of(d)), 64'(obs[d]), 64'({1'b1, {(OW - 1){1'b0}}}));
        chk_en = 1'b1;
        sync_rst = 1'b0;

        // Directed table.
        for (int i = 0; i < NVEC; i++) begin
            idle_all();
            for (int d = 0; d < NDUT; d++) begin
                fld_drv[d] = vecs[i].fld;
                seen[d] = 1'b0;
            end
            req_valid = 1'b1;
            req_write = vecs[i].wr;
            req_be    = vecs[i].be;
            req_wdata = vecs[i].wd;
            for (int k = 1; k <= 8; k++) begin
                step();
                req_valid = 1'b0;
                for (int d = 0; d < NDUT; d++) begin
                    if (k == 1) begin
                        check($sformatf("vec%0d lat%0d strobe", i, lat_of(d)),
                              64'({o_swr[d], o_sww[d], o_swd[d]}),
                              64'({(!vecs[i].wr && vecs[i].be != '0) ? vecs[i].be : 3'b000,
                                   ( vecs[i].wr && vecs[i].be != '0) ? vecs[i].be : 3'b000,
                                   ( vecs[i].wr && vecs[i].be != '0) ? vecs[i].wd : 12'h000}));
                    end
                    if (!seen[d] && o_rv[d]) begin
                        seen[d] = 1'b1;
                        check($sformatf("vec%0d lat%0d latency", i, lat_of(d)),
                              64'(k), 64'(lat_total(vecs[i].wr, vecs[i].be, d)));
                        check($sformatf("vec%0d lat%0d rsp", i, lat_of(d)),
                              64'({o_rw[d], o_err[d], o_rdata[d]}),
                              64'({vecs[i].wr, vecs[i].exp_err, vecs[i].exp_rd}));
                    end
                end
            end
            for (int d = 0; d < NDUT; d++)
                check($sformatf("vec%0d lat%0d rsp seen", i, lat_of(d)), 64'(seen[d]), 64'(1));
        end

        // Backpressure: response held, new request ignored, accepted right after handshake.
        idle_all();
        rsp_ready = 1'b0;
        for (int d = 0; d < NDUT; d++) fld_drv[d] = 12'h5A5;
        req_valid = 1'b1;
        req_write = 1'b0;
        req_be    = 3'b010;
        step();
        req_valid = 1'b0;
        repeat (4) step();
        req_valid = 1'b1;
        req_write = 1'b1;
        req_be    = 3'b111;
        req_wdata = 12'h123;
        for (int j = 0; j < 5; j++) begin
            step();
            for (int d = 0; d < NDUT; d++)
                check($sformatf("stall%0d lat%0d", j, lat_of(d)),
                      64'({o_ready[d], o_swr[d], o_sww[d], o_rv[d], o_rdata[d]}),
                      64'({1'b0, 3'b000, 3'b000, 1'b1, 12'h0A0}));
        end
        rsp_ready = 1'b1;
        step();
        for (int d = 0; d < NDUT; d++)
            check($sformatf("post-hs ready lat%0d", lat_of(d)),
                  64'({o_ready[d], o_rv[d]}), 64'({1'b1, 1'b0}));
        step();
        req_valid = 1'b0;
        for (int d = 0; d < NDUT; d++)
            check($sformatf("post-hs write lat%0d", lat_of(d)),
                  64'({o_sww[d], o_swd[d]}), 64'({3'b111, 12'h123}));

        // Reset while the RD_LAT=3 instance sits in its wait phase.
        idle_all();
        req_valid = 1'b1;
        req_write = 1'b0;
        req_be    = 3'b111;
        step();
        req_valid = 1'b0;
        step();
        sync_rst = 1'b1;
        step();
        sync_rst = 1'b0;
        check("rst-in-wait ready", 64'({o_ready[2], o_rv[2]}), 64'({1'b1, 1'b0}));
        for (int j = 0; j < 5; j++) begin
            step();
            check($sformatf("rst-in-wait quiet%0d", j), 64'({o_rv[2], o_swr[2]}), 64'(0));
        end

        // Randomised traffic: arbitrary valid/ready, per-cycle field data, rare resets.
        for (int n = 0; n < 3000; n++) begin
            step();
            req_valid = ($urandom_range(0, 1) == 1);
            req_write = ($urandom_range(0, 1) == 1);
            req_be    = NL'($urandom_range(0, 7));
            req_wdata = DW'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
            sync_rst  = ($urandom_range(0, 199) == 0);
            for (int d = 0; d < NDUT; d++) fld_drv[d] = DW'($urandom);
        end
        sync_rst = 1'b0;
        idle_all();
        step();
        chk_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
